// File: rtl/mul_issue_ctrl.sv
// Issue/collect stage in front of a fixed-latency multiplier: holds one request in flight,
// fires a single start pulse, captures the result after LAT cycles and holds it for writeback.
module mul_issue_ctrl #(
  parameter int LAT   = 3,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_a,
  input  logic [31:0]      io_in_b,
  input  logic [1:0]       io_in_op,
  input  logic [TAG_W-1:0] io_in_tag,
  output logic             io_mul_v,
  output logic [31:0]      io_mul_a,
  output logic [31:0]      io_mul_b,
  output logic [1:0]       io_mul_op,
  input  logic [31:0]      io_mul_res,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [31:0]      io_out_res,
  output logic [TAG_W-1:0] io_out_tag
);

  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             res_due;

  // A new request can enter while idle, or while the held result is leaving this cycle.
  assign io_in_ready = !io_flush && (state == IDLE || (state == DONE && io_out_ready));
  assign accept      = io_in_valid && io_in_ready;
  assign res_due     = (state == BUSY) && (cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      io_mul_v     <= 1'b0;
      io_out_valid <= 1'b0;
      io_mul_a     <= '0;
      io_mul_b     <= '0;
      io_mul_op    <= '0;
      tag_q        <= '0;
      io_out_res   <= '0;
      io_out_tag   <= '0;
    end else if (io_flush) begin
      state        <= IDLE;
      cnt          <= '0;
      io_mul_v     <= 1'b0;
      io_out_valid <= 1'b0;
    end else begin
      io_mul_v <= accept;
      if (accept) begin
        // Covers both the idle start and the zero-bubble restart from DONE.
        state        <= BUSY;
        cnt          <= CNT_W'(LAT);
        io_mul_a     <= io_in_a;
        io_mul_b     <= io_in_b;
        io_mul_op    <= io_in_op;
        tag_q        <= io_in_tag;
        io_out_valid <= 1'b0;
      end else begin
        case (state)
          BUSY: begin
            cnt <= cnt - CNT_W'(1);
            if (res_due) begin
              state        <= DONE;
              io_out_res   <= io_mul_res;
              io_out_tag   <= tag_q;
              io_out_valid <= 1'b1;
            end
          end
          DONE: begin
            if (io_out_ready) begin
              state        <= IDLE;
              io_out_valid <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: LAT=3 multiplier model, directed scenarios and a randomized run
// against a timestamp-based transaction model.
module tb_mul_issue_ctrl;
  localparam int LAT   = 3;
  localparam int TAG_W = 5;

  logic             clock        = 1'b0;
  logic             reset        = 1'b0;
  logic             io_flush     = 1'b0;
  logic             io_in_valid  = 1'b0;
  logic             io_in_ready;
  logic [31:0]      io_in_a      = '0;
  logic [31:0]      io_in_b      = '0;
  logic [1:0]       io_in_op     = '0;
  logic [TAG_W-1:0] io_in_tag    = '0;
  logic             io_mul_v;
  logic [31:0]      io_mul_a;
  logic [31:0]      io_mul_b;
  logic [1:0]       io_mul_op;
  logic [31:0]      io_mul_res   = '0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic [31:0]      io_out_res;
  logic [TAG_W-1:0] io_out_tag;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;

  // Model: one live op identified by the cycle it was accepted in.
  bit               m_live;
  int               m_acc;
  logic [31:0]      m_res, m_a, m_b;
  logic [1:0]       m_op;
  logic [TAG_W-1:0] m_tag;
  bit               e_ready, e_mv, e_ov;

  mul_issue_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_op(io_in_op), .io_in_tag(io_in_tag),
    .io_mul_v(io_mul_v), .io_mul_a(io_mul_a), .io_mul_b(io_mul_b), .io_mul_op(io_mul_op),
    .io_mul_res(io_mul_res),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_res(io_out_res), .io_out_tag(io_out_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier: result valid LAT-1 cycles after the start pulse, garbage otherwise.
  bit          pend = 1'b0;
  int          cd   = 0;
  logic [31:0] pres = '0;
  always @(negedge clock) begin
    if (io_mul_v === 1'b1) begin
      pend = 1'b1;
      cd   = LAT - 1;
      pres = ref_mul(io_mul_a, io_mul_b, io_mul_op);
    end else if (pend && cd > 0) begin
      cd--;
    end
    if (pend && cd == 0) begin
      io_mul_res = pres;
      pend       = 1'b0;
    end else begin
      io_mul_res = $urandom;
    end
  end

  task automatic model_reset();
    m_live = 1'b0; m_acc = 0; m_res = '0; m_a = '0; m_b = '0; m_op = '0; m_tag = '0;
  endtask

  task automatic set_in(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input bit ordy, input bit fl);
    io_in_valid = v; io_in_a = a; io_in_b = b; io_in_op = op; io_in_tag = tag;
    io_out_ready = ordy; io_flush = fl;
    #1;
    e_ov    = m_live && (cyc >= m_acc + LAT + 1);
    e_mv    = m_live && (cyc == m_acc + 1);
    e_ready = !fl && (!m_live || (e_ov && ordy));
  endtask

  task automatic clk_step();
    if (!reset) model_reset();
    else if (io_flush) m_live = 1'b0;
    else if (e_ready && io_in_valid) begin
      m_live = 1'b1; m_acc = cyc; m_a = io_in_a; m_b = io_in_b; m_op = io_in_op;
      m_tag = io_in_tag; m_res = ref_mul(io_in_a, io_in_b, io_in_op);
    end else if (e_ov && io_out_ready) m_live = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    model_reset();
    set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b0, 1'b0);
    cmp++;
    if ({io_mul_v, io_out_valid, io_mul_a, io_mul_b, io_mul_op, io_out_res, io_out_tag} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got mul_v=%b out_v=%b a=%h b=%h op=%h res=%h tag=%h want all 0",
               io_mul_v, io_out_valid, io_mul_a, io_mul_b, io_mul_op, io_out_res, io_out_tag);
    end
    cmp++;
    if (io_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", io_in_ready);
    end
    clk_step();
    clk_step();
    reset = 1'b1;
    set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    cmp++;
    if ({io_mul_v, io_out_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_release got mul_v=%b out_v=%b want 0 0", io_mul_v, io_out_valid);
    end
    clk_step();
  endtask

  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input logic [TAG_W-1:0] tag, input logic [31:0] res, input string nm);
    set_in(1'b1, a, b, op, tag, 1'b1, 1'b0);
    cmp++;
    if (io_in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_accept in_ready got=%b want=1", nm, io_in_ready);
    end
    clk_step();
    for (int k = 1; k <= LAT + 2; k++) begin
      set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
      cmp++;
      if (io_mul_v !== (k == 1)) begin
        bad++; $display("FAIL %s_mul_v k=%0d got=%b want=%b", nm, k, io_mul_v, (k == 1));
      end
      cmp++;
      if (io_out_valid !== (k == LAT + 1)) begin
        bad++; $display("FAIL %s_out_valid k=%0d got=%b want=%b", nm, k, io_out_valid, (k == LAT + 1));
      end
      if (k == 1) begin
        cmp++;
        if ({io_mul_a, io_mul_b, io_mul_op} !== {a, b, op}) begin
          bad++; $display("FAIL %s_operands got=%h/%h/%h want=%h/%h/%h", nm,
                          io_mul_a, io_mul_b, io_mul_op, a, b, op);
        end
      end
      if (k == LAT + 1) begin
        cmp++;
        if ({io_out_res, io_out_tag} !== {res, tag}) begin
          bad++; $display("FAIL %s_result got res=%h tag=%0d want res=%h tag=%0d", nm,
                          io_out_res, io_out_tag, res, tag);
        end
      end
      if (k == LAT + 2) begin
        cmp++;
        if (io_in_ready !== 1'b1) begin
          bad++; $display("FAIL %s_idle in_ready got=%b want=1", nm, io_in_ready);
        end
      end
      clk_step();
    end
  endtask

  task automatic test_single();
    run_single(32'd3, 32'd5, 2'b00, 5'd7, 32'd15, "single");
  endtask

  task automatic test_back_to_back();
    bit v, w_rdy, w_ov;
    set_in(1'b1, 32'hFFFF_FFFF, 32'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    clk_step();
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      v = (k <= LAT + 1);
      set_in(v, 32'd6, 32'd7, 2'b00, 5'd9, 1'b1, 1'b0);
      w_rdy = (k == LAT + 1) || (k >= 2 * LAT + 2);
      w_ov  = (k == LAT + 1) || (k == 2 * LAT + 2);
      cmp++;
      if (io_in_ready !== w_rdy) begin
        bad++; $display("FAIL b2b_in_ready k=%0d got=%b want=%b", k, io_in_ready, w_rdy);
      end
      cmp++;
      if (io_out_valid !== w_ov) begin
        bad++; $display("FAIL b2b_out_valid k=%0d got=%b want=%b", k, io_out_valid, w_ov);
      end
      cmp++;
      if (io_mul_v !== (k == 1 || k == LAT + 2)) begin
        bad++; $display("FAIL b2b_mul_v k=%0d got=%b", k, io_mul_v);
      end
      if (k == LAT + 1) begin
        cmp++;
        if ({io_out_res, io_out_tag} !== {32'h0000_0001, 5'd3}) begin
          bad++; $display("FAIL b2b_first got res=%h tag=%0d want res=00000001 tag=3", io_out_res, io_out_tag);
        end
      end
      if (k == 2 * LAT + 2) begin
        cmp++;
        if ({io_out_res, io_out_tag} !== {32'd42, 5'd9}) begin
          bad++; $display("FAIL b2b_second got res=%h tag=%0d want res=0000002a tag=9", io_out_res, io_out_tag);
        end
      end
      clk_step();
    end
  endtask

  task automatic test_backpressure();
    bit ordy, w_ov;
    set_in(1'b1, 32'h8000_0000, 32'h8000_0000, 2'b01, 5'd12, 1'b0, 1'b0);
    clk_step();
    for (int k = 1; k <= LAT + 7; k++) begin
      ordy = (k >= LAT + 6);
      set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, ordy, 1'b0);
      w_ov = (k >= LAT + 1) && (k <= LAT + 6);
      cmp++;
      if (io_out_valid !== w_ov) begin
        bad++; $display("FAIL bp_out_valid k=%0d got=%b want=%b", k, io_out_valid, w_ov);
      end
      cmp++;
      if (io_in_ready !== (k >= LAT + 6)) begin
        bad++; $display("FAIL bp_in_ready k=%0d got=%b want=%b", k, io_in_ready, (k >= LAT + 6));
      end
      if (w_ov) begin
        cmp++;
        if ({io_out_res, io_out_tag} !== {32'h4000_0000, 5'd12}) begin
          bad++; $display("FAIL bp_result k=%0d got res=%h tag=%0d want res=40000000 tag=12",
                          k, io_out_res, io_out_tag);
        end
      end
      clk_step();
    end
  endtask

  task automatic test_flush_busy();
    set_in(1'b1, 32'd9, 32'd9, 2'b00, 5'd1, 1'b1, 1'b0);
    clk_step();
    for (int k = 1; k <= LAT + 5; k++) begin
      set_in(k <= 2, 32'd11, 32'd13, 2'b00, 5'd2, 1'b1, k == 2);
      if (k <= 2) begin
        cmp++;
        if (io_in_ready !== 1'b0) begin
          bad++; $display("FAIL flush_busy_in_ready k=%0d got=%b want=0", k, io_in_ready);
        end
      end else begin
        cmp++;
        if ({io_out_valid, io_mul_v} !== 2'b00) begin
          bad++; $display("FAIL flush_busy_killed k=%0d got out_v=%b mul_v=%b want 0 0",
                          k, io_out_valid, io_mul_v);
        end
      end
      clk_step();
    end
    run_single(32'd100, 32'd200, 2'b00, 5'd4, 32'd20000, "after_flush");
  endtask

  task automatic test_flush_done();
    set_in(1'b1, 32'hFFFF_FFFF, 32'd2, 2'b10, 5'd20, 1'b0, 1'b0);
    clk_step();
    for (int k = 1; k <= LAT; k++) begin
      set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b0, 1'b0);
      clk_step();
    end
    set_in(1'b1, 32'd1, 32'd1, 2'b00, 5'd21, 1'b1, 1'b1);
    cmp++;
    if ({io_out_valid, io_out_res} !== {1'b1, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL flush_done_held got out_v=%b res=%h want 1 ffffffff", io_out_valid, io_out_res);
    end
    cmp++;
    if (io_in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_done_in_ready got=%b want=0", io_in_ready);
    end
    clk_step();
    for (int k = 1; k <= LAT + 1; k++) begin
      set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
      cmp++;
      if ({io_out_valid, io_mul_v, io_in_ready} !== 3'b001) begin
        bad++; $display("FAIL flush_done_idle k=%0d got out_v=%b mul_v=%b in_ready=%b want 0 0 1",
                        k, io_out_valid, io_mul_v, io_in_ready);
      end
      clk_step();
    end
  endtask

  task automatic test_reset_mid_busy();
    set_in(1'b1, 32'd17, 32'd19, 2'b00, 5'd6, 1'b1, 1'b0);
    clk_step();
    set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    clk_step();
    set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    cmp++;
    if ({io_mul_v, io_out_valid, io_mul_a, io_mul_b, io_mul_op, io_out_res, io_out_tag} !== '0) begin
      bad++; $display("FAIL async_reset_outputs got mul_v=%b out_v=%b a=%h b=%h res=%h tag=%0d want all 0",
                      io_mul_v, io_out_valid, io_mul_a, io_mul_b, io_out_res, io_out_tag);
    end
    cmp++;
    if (io_in_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset_idle in_ready got=%b want=1", io_in_ready);
    end
    clk_step();
    set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    clk_step();
    reset = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      set_in(1'b0, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1, 1'b0);
      cmp++;
      if ({io_mul_v, io_out_valid} !== 2'b00) begin
        bad++; $display("FAIL async_reset_stray k=%0d got mul_v=%b out_v=%b want 0 0",
                        k, io_mul_v, io_out_valid);
      end
      clk_step();
    end
  endtask

  task automatic test_random();
    bit v, ordy, fl;
    logic [31:0] a, b;
    for (int i = 0; i < 600; i++) begin
      v    = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 19) == 0);
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      set_in(v, a, b, 2'($urandom_range(0, 3)), TAG_W'($urandom), ordy, fl);
      cmp++;
      if ({io_in_ready, io_mul_v, io_out_valid} !== {e_ready, e_mv, e_ov}) begin
        bad++; $display("FAIL rand_ctrl i=%0d got rdy/mv/ov=%b%b%b want=%b%b%b", i,
                        io_in_ready, io_mul_v, io_out_valid, e_ready, e_mv, e_ov);
      end
      cmp++;
      if ({io_mul_a, io_mul_b, io_mul_op} !== {m_a, m_b, m_op}) begin
        bad++; $display("FAIL rand_operands i=%0d got=%h/%h/%h want=%h/%h/%h", i,
                        io_mul_a, io_mul_b, io_mul_op, m_a, m_b, m_op);
      end
      if (e_ov) begin
        cmp++;
        if ({io_out_res, io_out_tag} !== {m_res, m_tag}) begin
          bad++; $display("FAIL rand_result i=%0d got res=%h tag=%0d want res=%h tag=%0d", i,
                          io_out_res, io_out_tag, m_res, m_tag);
        end
      end
      clk_step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush_busy();
    test_flush_done();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
